// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
//   arb_state_e : transaction phase (idle, memory access, response)
//   NUM_PORTS   : number of requesters sharing the memory
//   be_to_mask  : expands one byte-enable bit into its 8-bit lane mask
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } arb_state_e;

    localparam int unsigned NUM_PORTS = 2;

    function automatic logic [7:0] be_to_mask(input logic be_bit);
        return {8{be_bit}};
    endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way request picker.
//   req         : per-port request
//   last        : index of the port granted most recently
//   en          : picker may grant this cycle
//   gnt         : onehot0 grant
// With ROUND_ROBIN set, a tie goes to the port that was not granted last;
// otherwise port 0 always wins a tie. A lone request is always granted.
module dmem_rr_pick #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       en,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = (ROUND_ROBIN && !last) ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between the pipeline (port 0) and the
// loader (port 1). One transaction every three cycles: grant, memory access,
// response. Byte-enable writes are merged read-modify-write in the access
// cycle, relying on the memory's combinational read.
//   clk, rst_n         : clock, asynchronous active-low reset
//   req/we/be/addr/wdata : per-port request and its fields, held until gnt
//   gnt                : one-cycle accept pulse (combinational)
//   rvalid, rdata      : one-cycle completion pulse and shared read data
//   mem_a/mem_wd/mem_we: memory address, write data, write enable
//   mem_rd             : memory read data
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ROUND_ROBIN   = 1
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [NUM_PORTS-1:0]                      req,
    input  logic [NUM_PORTS-1:0]                      we,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0]    be,
    input  logic [NUM_PORTS-1:0][ADDRESS_WIDTH-1:0]   addr,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]      wdata,
    output logic [NUM_PORTS-1:0]                      gnt,
    output logic [NUM_PORTS-1:0]                      rvalid,
    output logic [DATA_WIDTH-1:0]                     rdata,
    output logic [ADDRESS_WIDTH-1:0]                  mem_a,
    output logic [DATA_WIDTH-1:0]                     mem_wd,
    output logic                                      mem_we,
    input  logic [DATA_WIDTH-1:0]                     mem_rd
);

    localparam int unsigned NumBytes = DATA_WIDTH / 8;

    arb_state_e               state_q;
    logic                     port_q;
    logic                     we_q;
    logic                     last_q;
    logic [NumBytes-1:0]      be_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic [NUM_PORTS-1:0]     rvalid_q;
    logic [DATA_WIDTH-1:0]    rdata_q;
    logic [DATA_WIDTH-1:0]    byte_mask;
    logic                     pick_en;
    logic                     gnt_port;

    // Gating with rst_n keeps gnt low while reset is held, even with req high.
    assign pick_en  = (state_q == StIdle) && rst_n;
    assign gnt_port = gnt[1];

    dmem_rr_pick #(
        .ROUND_ROBIN(ROUND_ROBIN != 0)
    ) u_pick (
        .req (req),
        .last(last_q),
        .en  (pick_en),
        .gnt (gnt)
    );

    for (genvar i = 0; i < NumBytes; i++) begin : g_mask
        assign byte_mask[8*i +: 8] = be_to_mask(be_q[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            port_q   <= 1'b0;
            we_q     <= 1'b0;
            be_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            last_q   <= 1'b1;  // port 0 wins the first tie
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= '0;
            case (state_q)
                StIdle: begin
                    if (|gnt) begin
                        port_q  <= gnt_port;
                        we_q    <= we[gnt_port];
                        be_q    <= be[gnt_port];
                        addr_q  <= addr[gnt_port];
                        wdata_q <= wdata[gnt_port];
                        last_q  <= gnt_port;
                        state_q <= StAccess;
                    end
                end
                StAccess: begin
                    // Captures the pre-write word for writes.
                    rdata_q          <= mem_rd;
                    rvalid_q[port_q] <= 1'b1;
                    state_q          <= StResp;
                end
                StResp:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // Memory side is combinational from state so a reset mid-access kills
    // mem_we immediately.
    always_comb begin
        mem_a  = '0;
        mem_wd = '0;
        mem_we = 1'b0;
        if (state_q == StAccess) begin
            mem_a = addr_q;
            if (we_q) begin
                mem_wd = (mem_rd & ~byte_mask) | (wdata_q & byte_mask);
                mem_we = |be_q;
            end
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic             clk;
    logic             rst_n;
    logic [1:0]       req;
    logic [1:0]       we;
    logic [1:0][3:0]  be;
    logic [1:0][31:0] addr;
    logic [1:0][31:0] wdata;

    // Index 0: round-robin instance, index 1: fixed-priority instance.
    logic [1:0]  gnt_w    [2];
    logic [1:0]  rvalid_w [2];
    logic [31:0] rdata_w  [2];
    logic [31:0] mem_a_w  [2];
    logic [31:0] mem_wd_w [2];
    logic        mem_we_w [2];
    logic [31:0] mem_rd_w [2];

    logic [31:0] hmem [2][16];
    bit          mem_loaded = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    dmem_arbiter #(
        .ADDRESS_WIDTH(32),
        .DATA_WIDTH   (32),
        .ROUND_ROBIN  (1)
    ) dut_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .we    (we),
        .be    (be),
        .addr  (addr),
        .wdata (wdata),
        .gnt   (gnt_w[0]),
        .rvalid(rvalid_w[0]),
        .rdata (rdata_w[0]),
        .mem_a (mem_a_w[0]),
        .mem_wd(mem_wd_w[0]),
        .mem_we(mem_we_w[0]),
        .mem_rd(mem_rd_w[0])
    );

    dmem_arbiter #(
        .ADDRESS_WIDTH(32),
        .DATA_WIDTH   (32),
        .ROUND_ROBIN  (0)
    ) dut_fp (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .we    (we),
        .be    (be),
        .addr  (addr),
        .wdata (wdata),
        .gnt   (gnt_w[1]),
        .rvalid(rvalid_w[1]),
        .rdata (rdata_w[1]),
        .mem_a (mem_a_w[1]),
        .mem_wd(mem_wd_w[1]),
        .mem_we(mem_we_w[1]),
        .mem_rd(mem_rd_w[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] init_word(input int i);
        case (i)
            1:       return 32'hDEAD_BEEF;
            2:       return 32'hAABB_CCDD;
            3:       return 32'h5566_7788;
            default: return 32'h0101_0101 * (i + 1);
        endcase
    endfunction

    // Data memory stand-in: combinational read, write at the clock edge.
    assign mem_rd_w[0] = hmem[0][mem_a_w[0][5:2]];
    assign mem_rd_w[1] = hmem[1][mem_a_w[1][5:2]];

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < 16; i++) hmem[k][i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else begin
            for (int k = 0; k < 2; k++)
                if (mem_we_w[k]) hmem[k][mem_a_w[k][5:2]] <= mem_wd_w[k];
        end
    end

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d: got %h, expected %h at %0t", name, k, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        bit          active;
        int          age;     // 1: memory cycle next, 2: response next
        bit          port;
        bit          we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t        txn_m     [2];
    bit          last_m    [2];
    logic [31:0] rdata_m   [2];
    logic [1:0]  exp_gnt_m [2];
    logic [31:0] ref_mem   [2][16];

    function automatic logic [1:0] arb(input logic [1:0] r, input bit rr, input bit last);
        if (r == 2'b11) begin
            if (rr) return last ? 2'b01 : 2'b10;
            return 2'b01;
        end
        return r;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] b);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    task automatic model_reset(input int k);
        txn_m[k].active = 1'b0;
        txn_m[k].age    = 0;
        last_m[k]       = 1'b1;
        rdata_m[k]      = '0;
        exp_gnt_m[k]    = '0;
    endtask

    task automatic model_check(input int k);
        logic [1:0]  eg;
        logic [1:0]  erv;
        logic [31:0] ea;
        logic [31:0] ewd;
        logic        ewe;
        eg = '0; erv = '0; ea = '0; ewd = '0; ewe = 1'b0;
        if (!rst_n) begin
            model_reset(k);
        end else if (!txn_m[k].active) begin
            eg = arb(req, k == 0, last_m[k]);
        end else if (txn_m[k].age == 1) begin
            ea = txn_m[k].addr;
            if (txn_m[k].we) begin
                ewd = merge(ref_mem[k][txn_m[k].addr[5:2]], txn_m[k].wdata, txn_m[k].be);
                ewe = |txn_m[k].be;
            end
        end else begin
            erv[txn_m[k].port] = 1'b1;
        end
        exp_gnt_m[k] = eg;
        check("gnt",    k, gnt_w[k],    eg);
        check("rvalid", k, rvalid_w[k], erv);
        check("rdata",  k, rdata_w[k],  rdata_m[k]);
        check("mem_a",  k, mem_a_w[k],  ea);
        check("mem_wd", k, mem_wd_w[k], ewd);
        check("mem_we", k, mem_we_w[k], ewe);
    endtask

    task automatic model_step(input int k);
        int p;
        int idx;
        if (!rst_n) begin
            model_reset(k);
        end else begin
            if (txn_m[k].active) begin
                if (txn_m[k].age == 1) begin
                    idx = int'(txn_m[k].addr[5:2]);
                    rdata_m[k] = ref_mem[k][idx];
                    if (txn_m[k].we && |txn_m[k].be)
                        ref_mem[k][idx] = merge(ref_mem[k][idx], txn_m[k].wdata, txn_m[k].be);
                    txn_m[k].age = 2;
                end else begin
                    txn_m[k].active = 1'b0;
                end
            end
            if (exp_gnt_m[k] != 2'b00) begin
                p = exp_gnt_m[k][1] ? 1 : 0;
                txn_m[k].active = 1'b1;
                txn_m[k].age    = 1;
                txn_m[k].port   = p[0];
                txn_m[k].we     = we[p];
                txn_m[k].be     = be[p];
                txn_m[k].addr   = addr[p];
                txn_m[k].wdata  = wdata[p];
                last_m[k]       = p[0];
            end
        end
    endtask

    initial begin : model_proc
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) ref_mem[k][i] = init_word(i);
            model_reset(k);
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) model_check(k);
            @(posedge clk);
            for (int k = 0; k < 2; k++) model_step(k);
        end
    end

    // ---------------- stimulus and literal expectations ----------------
    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        req   = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic run_txn(input int p, input logic w, input logic [3:0] b,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] exp_rd, input logic exp_we);
        @(posedge clk); #1;
        req      = '0;
        req[p]   = 1'b1;
        we[p]    = w;
        be[p]    = b;
        addr[p]  = a;
        wdata[p] = d;
        @(negedge clk);
        for (int k = 0; k < 2; k++) check("lit_gnt", k, gnt_w[k], 32'd1 << p);
        @(posedge clk); #1;
        req = '0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) check("lit_mem_we", k, mem_we_w[k], exp_we);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("lit_rvalid", k, rvalid_w[k], 32'd1 << p);
            check("lit_rdata",  k, rdata_w[k],  exp_rd);
        end
    endtask

    initial begin : stim
        int          n_g [2];
        logic [1:0]  gseq [2][4];
        logic [1:0]  rr_exp [4];
        int          first_g;
        int          prev_g;
        int          min_gap;
        int          cnt;
        int          a;

        rst_n = 1'b0;
        req   = '0;
        we    = '0;
        be    = '0;
        addr  = '0;
        wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state.
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("lit_rst_gnt",    k, gnt_w[k],    0);
            check("lit_rst_rvalid", k, rvalid_w[k], 0);
            check("lit_rst_rdata",  k, rdata_w[k],  0);
            check("lit_rst_mem_we", k, mem_we_w[k], 0);
        end

        // Port 0 read of 0xDEADBEEF at address 4.
        run_txn(0, 1'b0, 4'h0, 32'd4, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // Port 1 byte-merged write.
        run_txn(1, 1'b1, 4'b0110, 32'd8, 32'h1122_3344, 32'hAABB_CCDD, 1'b1);
        for (int k = 0; k < 2; k++) check("lit_merge", k, hmem[k][2], 32'hAA22_33DD);

        // Write with no byte enables: no memory write, still completes.
        run_txn(0, 1'b1, 4'h0, 32'd12, 32'hFFFF_FFFF, 32'h5566_7788, 1'b0);
        for (int k = 0; k < 2; k++) check("lit_be0_mem", k, hmem[k][3], 32'h5566_7788);

        // Both ports requesting continuously from reset.
        do_reset();
        req = 2'b11;
        we  = 2'b00;
        for (int k = 0; k < 2; k++) n_g[k] = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (gnt_w[k] != 2'b00) begin
                    if (n_g[k] < 4) gseq[k][n_g[k]] = gnt_w[k];
                    n_g[k]++;
                end
            end
        end
        @(posedge clk); #1;
        req = '0;
        rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;
        check("lit_tie_count", 0, n_g[0], 4);
        check("lit_tie_count", 1, n_g[1], 4);
        for (int j = 0; j < 4; j++) begin
            if (j < n_g[0]) check("lit_tie_rr", 0, gseq[0][j], rr_exp[j]);
            if (j < n_g[1]) check("lit_tie_fp", 1, gseq[1][j], 2'b01);
        end
        repeat (3) @(posedge clk);
        #1;

        // Reset during the memory cycle of a write.
        req      = 2'b01;
        we[0]    = 1'b1;
        be[0]    = 4'hF;
        addr[0]  = 32'd12;
        wdata[0] = 32'hCAFE_F00D;
        @(negedge clk);
        for (int k = 0; k < 2; k++) check("lit_rw_gnt", k, gnt_w[k], 2'b01);
        @(posedge clk); #1;
        req = '0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) check("lit_rw_we_pre", k, mem_we_w[k], 1);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("lit_rw_we_drop", k, mem_we_w[k], 0);
            check("lit_rw_mem_a",   k, mem_a_w[k],  0);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("lit_rw_rvalid", k, rvalid_w[k], 0);
            check("lit_rw_mem",    k, hmem[k][3],  32'h5566_7788);
        end
        @(posedge clk); #1;
        req = 2'b11;
        we  = 2'b00;
        @(negedge clk);
        for (int k = 0; k < 2; k++) check("lit_post_rst_tie", k, gnt_w[k], 2'b01);
        @(posedge clk); #1;
        req = '0;
        repeat (3) @(posedge clk);
        #1;

        // Port 0 requesting back to back.
        req   = 2'b01;
        we[0] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_g[k] = 0;
        end
        first_g = -1;
        prev_g  = -1;
        min_gap = 1000;
        cnt     = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (gnt_w[0] != 2'b00) begin
                if (first_g < 0) first_g = c;
                if (prev_g >= 0 && (c - prev_g) < min_gap) min_gap = c - prev_g;
                prev_g = c;
                cnt++;
            end
        end
        @(posedge clk); #1;
        req = '0;
        check("lit_b2b_count", 0, cnt,     4);
        check("lit_b2b_first", 0, first_g, 0);
        check("lit_b2b_gap",   0, min_gap, 3);
        repeat (3) @(posedge clk);
        #1;

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 1500; i++) begin
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
            req = 2'($urandom_range(0, 3));
            we  = 2'($urandom_range(0, 3));
            for (int p = 0; p < 2; p++) begin
                be[p]    = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                a        = int'($urandom_range(0, 15));
                addr[p]  = 32'(a) << 2;
                wdata[p] = $urandom;
            end
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        req   = '0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 16; i++) check("final_mem", k, hmem[k][i], ref_mem[k][i]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
